bias_relu_fire4_expand3: RTL and testbench

//  Consumer of the fire4 expand3x3 bias table. Takes the conv engine's 32-bit accumulator stream, channel-major per pixel.

---
 rtl/fire_pkg.sv | 31 +++
 rtl/pipe_stage_vr.sv | 35 +++
 rtl/bias_relu_fire4_expand3.sv | 140 ++++++++++++++
 tb/tb_bias_relu_fire4_expand3.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// Shared constants, post-processing FSM state type and the shift/saturate helper
// used by the fire4 bias/activation blocks.
package fire_pkg;

   localparam int ACC_W        = 32;
   localparam int OUT_W        = 16;
   localparam int FIRE4_NUM_CH = 128;
   localparam int FIRE4_PIXELS = 729;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} post_state_t;

   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (OUT_W-1)));

   // Arithmetic shift of the 33-bit biased sum, then clamp into the signed output range.
   function automatic logic signed [OUT_W-1:0] sat_shift(input logic signed [ACC_W:0] sum,
                                                         input int shift);
      logic signed [ACC_W:0]   sh;
      logic signed [OUT_W-1:0] res;
      sh = sum >>> shift;
      if (sh > SAT_MAX) begin
         res = SAT_MAX[OUT_W-1:0];
      end else if (sh < SAT_MIN) begin
         res = SAT_MIN[OUT_W-1:0];
      end else begin
         res = sh[OUT_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/pipe_stage_vr.sv
// Generic valid/ready register slice: loads whenever it is empty or its consumer
// takes the current word, otherwise holds data and valid unchanged.
module pipe_stage_vr #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   assign in_ready_o  = !valid_q || out_ready_i;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (in_ready_o) begin
         valid_q <= in_valid_i;
         if (in_valid_i) begin
            data_q <= in_data_i;
         end
      end
   end

endmodule

// File: rtl/bias_relu_fire4_expand3.sv
// fire4 expand3x3 post-processing: per-channel bias add, shift/saturate and, when
// BIAS_RELU_EN is defined, ReLU; framed by an IDLE/RUN/DRAIN start/done FSM.
module bias_relu_fire4_expand3
   import fire_pkg::*;
#(
   parameter int NUM_CH     = FIRE4_NUM_CH,
   parameter int PIXELS     = FIRE4_PIXELS,
   parameter int FRAC_SHIFT = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0][ACC_W-1:0] bias_mem,
   input  logic                         start,
   input  logic                         acc_valid,
   output logic                         acc_ready,
   input  logic [ACC_W-1:0]             acc_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_W-1:0]             out_data,
   output logic [$clog2(NUM_CH)-1:0]    out_ch,
   output logic                         out_last,
   output logic                         busy,
   output logic                         done
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int S1_W  = 1 + CH_W + ACC_W + 1;
   localparam int S2_W  = 1 + CH_W + OUT_W;

   post_state_t             state_q, state_d;
   logic [CH_W-1:0]         chCnt_q, chCnt_d;
   logic [PIX_W-1:0]        pixCnt_q, pixCnt_d;
   logic                    done_q, done_d;
   logic                    accHs, chWrap, frameLast;
   logic [ACC_W-1:0]        biasSel;
   logic signed [ACC_W:0]   biasedSum;
   logic                    s1InValid, s1InReady, s1Valid, s2InReady, s2Valid;
   logic [S1_W-1:0]         s1In, s1Out;
   logic [S2_W-1:0]         s2In, s2Out;
   logic                    s1Last;
   logic [CH_W-1:0]         s1Ch;
   logic signed [ACC_W:0]   s1Sum;
   logic signed [OUT_W-1:0] act;

   assign s1InValid = acc_valid && (state_q == RUN);
   assign acc_ready = (state_q == RUN) && s1InReady;
   assign accHs     = acc_valid && acc_ready;
   assign chWrap    = (chCnt_q == CH_W'(NUM_CH - 1));
   assign frameLast = chWrap && (pixCnt_q == PIX_W'(PIXELS - 1));
   assign biasSel   = bias_mem[chCnt_q];
   assign biasedSum = $signed({acc_data[ACC_W-1], acc_data}) + $signed({biasSel[ACC_W-1], biasSel});

   // Channel-major walk: channel advances every accepted word, pixel on channel wrap.
   always_comb begin
      chCnt_d  = chCnt_q;
      pixCnt_d = pixCnt_q;
      if (accHs) begin
         if (chWrap) begin
            chCnt_d  = '0;
            pixCnt_d = (pixCnt_q == PIX_W'(PIXELS - 1)) ? '0 : pixCnt_q + PIX_W'(1);
         end else begin
            chCnt_d = chCnt_q + CH_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accHs && frameLast) state_d = DRAIN;
         DRAIN: begin
            if (!s1Valid && !s2Valid) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         chCnt_q  <= '0;
         pixCnt_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         chCnt_q  <= chCnt_d;
         pixCnt_q <= pixCnt_d;
         done_q   <= done_d;
      end
   end

   assign s1In = {frameLast, chCnt_q, biasedSum};

   pipe_stage_vr #(.W(S1_W)) u_stage1 (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (s1InValid),
      .in_ready_o  (s1InReady),
      .in_data_i   (s1In),
      .out_valid_o (s1Valid),
      .out_ready_i (s2InReady),
      .out_data_o  (s1Out)
   );

   assign {s1Last, s1Ch, s1Sum} = s1Out;

   always_comb begin
      act = sat_shift(s1Sum, FRAC_SHIFT);
`ifdef BIAS_RELU_EN
      if (act[OUT_W-1]) begin
         act = '0;
      end
`endif
   end

   assign s2In = {s1Last, s1Ch, act};

   pipe_stage_vr #(.W(S2_W)) u_stage2 (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (s1Valid),
      .in_ready_o  (s2InReady),
      .in_data_i   (s2In),
      .out_valid_o (s2Valid),
      .out_ready_i (out_ready),
      .out_data_o  (s2Out)
   );

   assign {out_last, out_ch, out_data} = s2Out;
   assign out_valid = s2Valid;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_bias_relu_fire4_expand3.sv
// Directed bench for bias_relu_fire4_expand3 (BIAS_RELU_EN selects the expected activations).
// Instance 0/1 use FRAC_SHIFT=0 (1 hosts the mid-frame reset), instance 2 uses FRAC_SHIFT=4.
module tb_bias_relu_fire4_expand3;

   typedef struct packed {
      logic signed [15:0] data;
      logic [6:0]         ch;
      logic               last;
   } obs_t;

   localparam int FRAME_WORDS = 128 * 729;
   localparam int RST_WORDS   = 300 * 128 + 57;
`ifdef BIAS_RELU_EN
   localparam logic signed [15:0] EXP_CH0_ZERO = 16'sd0;
   localparam logic signed [15:0] EXP_NEG_SAT  = 16'sd0;
   localparam logic signed [15:0] EXP_SH_CH0   = 16'sd0;
`else
   localparam logic signed [15:0] EXP_CH0_ZERO = -16'sd61;
   localparam logic signed [15:0] EXP_NEG_SAT  = 16'sh8000;
   localparam logic signed [15:0] EXP_SH_CH0   = -16'sd4;
`endif

   logic                clk = 1'b0;
   logic [2:0]          rst, start, acc_valid, out_ready;
   logic [2:0]          acc_ready, out_valid, out_last, busy, done;
   logic [31:0]         acc_data [3];
   logic signed [15:0]  out_data [3];
   logic [6:0]          out_ch [3];
   logic [127:0][31:0]  bias_tb;
   obs_t                mq [3][$];
   int                  n_checks = 0;
   int                  n_pass = 0;

   always #5 clk = ~clk;

   bias_relu_fire4_expand3 #(.NUM_CH(128), .PIXELS(729), .FRAC_SHIFT(0)) dut (
      .clk(clk), .rst(rst[0]), .bias_mem(bias_tb), .start(start[0]),
      .acc_valid(acc_valid[0]), .acc_ready(acc_ready[0]), .acc_data(acc_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_ch(out_ch[0]), .out_last(out_last[0]), .busy(busy[0]), .done(done[0]));

   bias_relu_fire4_expand3 #(.NUM_CH(128), .PIXELS(729), .FRAC_SHIFT(0)) dut_rst (
      .clk(clk), .rst(rst[1]), .bias_mem(bias_tb), .start(start[1]),
      .acc_valid(acc_valid[1]), .acc_ready(acc_ready[1]), .acc_data(acc_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_ch(out_ch[1]), .out_last(out_last[1]), .busy(busy[1]), .done(done[1]));

   bias_relu_fire4_expand3 #(.NUM_CH(128), .PIXELS(2), .FRAC_SHIFT(4)) dut_sh (
      .clk(clk), .rst(rst[2]), .bias_mem(bias_tb), .start(start[2]),
      .acc_valid(acc_valid[2]), .acc_ready(acc_ready[2]), .acc_data(acc_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
      .out_ch(out_ch[2]), .out_last(out_last[2]), .busy(busy[2]), .done(done[2]));

   // Output handshakes are recorded mid-cycle, where inputs and outputs are settled.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (out_valid[d] && out_ready[d]) mq[d].push_back({out_data[d], out_ch[d], out_last[d]});
      end
   end

   initial begin
      #990000;
      $display("[TB] FAIL watchdog expired got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic signed [15:0] exp_act(input logic signed [31:0] acc,
                                                  input logic signed [31:0] bias, input int shift);
      longint s;
      s = longint'(acc) + longint'(bias);
      s = s >>> shift;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`ifdef BIAS_RELU_EN
      if (s < 0) s = 0;
`endif
      return 16'(s);
   endfunction

   function automatic logic [31:0] acc4(input int i);
      if (i % 7 == 3) return 32'(2000000000 - i);
      if (i % 7 == 5) return 32'(-2000000000 + i);
      return 32'((i - 20) * 1237);
   endfunction

   task automatic applyStimulus(input int d, input logic [31:0] a, output bit ok);
      ok = 1'b0;
      acc_valid[d] = 1'b1;
      acc_data[d]  = a;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = acc_ready[d];
         @(posedge clk);
         #1;
      end
      acc_valid[d] = 1'b0;
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b1;
      @(posedge clk);
      #1;
      rst[d] = 1'b0;
      mq[d].delete();
   endtask

   task automatic start_frame(input int d);
      start[d] = 1'b1;
      @(posedge clk);
      #1;
      start[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 3'b111;
      #12;
      for (int d = 0; d < 3; d++) begin
         n_checks += 7;
         if (out_valid[d] !== 1'b0) $display("[TB] FAIL rst_out_valid[%0d] got %0b expected 0", d, out_valid[d]); else n_pass++;
         if (out_data[d] !== 16'sd0) $display("[TB] FAIL rst_out_data[%0d] got %0d expected 0", d, out_data[d]); else n_pass++;
         if (out_ch[d] !== 7'd0) $display("[TB] FAIL rst_out_ch[%0d] got %0d expected 0", d, out_ch[d]); else n_pass++;
         if (out_last[d] !== 1'b0) $display("[TB] FAIL rst_out_last[%0d] got %0b expected 0", d, out_last[d]); else n_pass++;
         if (busy[d] !== 1'b0) $display("[TB] FAIL rst_busy[%0d] got %0b expected 0", d, busy[d]); else n_pass++;
         if (done[d] !== 1'b0) $display("[TB] FAIL rst_done[%0d] got %0b expected 0", d, done[d]); else n_pass++;
         if (acc_ready[d] !== 1'b0) $display("[TB] FAIL rst_acc_ready[%0d] got %0b expected 0", d, acc_ready[d]); else n_pass++;
      end
      @(posedge clk);
      #1;
      rst = 3'b000;
   endtask

   task automatic test_basic_latency();
      bit ok;
      do_reset(0);
      out_ready[0] = 1'b1;
      start_frame(0);
      n_checks++;
      if (busy[0] !== 1'b1) $display("[TB] FAIL t1_busy got %0b expected 1", busy[0]); else n_pass++;
      applyStimulus(0, 32'd100, ok);
      n_checks += 5;
      if (ok !== 1'b1) $display("[TB] FAIL t1_accept got %0b expected 1", ok); else n_pass++;
      if (out_valid[0] !== 1'b0) $display("[TB] FAIL t1_valid_early got %0b expected 0", out_valid[0]); else n_pass++;
      @(posedge clk);
      #1;
      if (out_valid[0] !== 1'b1) $display("[TB] FAIL t1_valid_lat2 got %0b expected 1", out_valid[0]); else n_pass++;
      if (out_data[0] !== 16'sd39) $display("[TB] FAIL t1_data got %0d expected 39", out_data[0]); else n_pass++;
      if (out_ch[0] !== 7'd0) $display("[TB] FAIL t1_ch got %0d expected 0", out_ch[0]); else n_pass++;
   endtask

   task automatic test_saturation();
      bit ok;
      logic [31:0] vals [6];
      vals = '{32'd0, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd0, 32'h80000000};
      do_reset(0);
      out_ready[0] = 1'b1;
      start_frame(0);
      foreach (vals[i]) applyStimulus(0, vals[i], ok);
      repeat (4) @(posedge clk);
      #1;
      n_checks += 5;
      if (mq[0].size() !== 6) $display("[TB] FAIL t2_count got %0d expected 6", mq[0].size()); else n_pass++;
      if (mq[0][3].data !== 16'sd32767) $display("[TB] FAIL t2_pos_sat got %0d expected 32767", mq[0][3].data); else n_pass++;
      if (mq[0][3].ch !== 7'd3) $display("[TB] FAIL t2_pos_ch got %0d expected 3", mq[0][3].ch); else n_pass++;
      if (mq[0][5].data !== EXP_NEG_SAT) $display("[TB] FAIL t2_neg_sat got %0d expected %0d", mq[0][5].data, EXP_NEG_SAT); else n_pass++;
      if (mq[0][5].ch !== 7'd5) $display("[TB] FAIL t2_neg_ch got %0d expected 5", mq[0][5].ch); else n_pass++;
   endtask

   task automatic test_relu();
      bit ok;
      do_reset(0);
      out_ready[0] = 1'b1;
      start_frame(0);
      applyStimulus(0, 32'd0, ok);
      repeat (3) @(posedge clk);
      #1;
      n_checks += 2;
      if (mq[0][0].data !== EXP_CH0_ZERO) $display("[TB] FAIL t3_relu got %0d expected %0d", mq[0][0].data, EXP_CH0_ZERO); else n_pass++;
      if (mq[0].size() !== 1) $display("[TB] FAIL t3_count got %0d expected 1", mq[0].size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int fails;
      do_reset(0);
      out_ready[0] = 1'b1;
      start_frame(0);
      fails = 0;
      fork
         begin
            bit ok;
            for (int i = 0; i < 40; i++) begin
               applyStimulus(0, acc4(i), ok);
               if (!ok) fails++;
            end
         end
         begin
            logic signed [15:0] hd;
            logic [6:0]         hc;
            repeat (10) @(posedge clk);
            #1;
            out_ready[0] = 1'b0;
            hd = out_data[0];
            hc = out_ch[0];
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               n_checks += 4;
               if (acc_ready[0] !== 1'b0) $display("[TB] FAIL t4_acc_ready_low got %0b expected 0", acc_ready[0]); else n_pass++;
               if (out_valid[0] !== 1'b1) $display("[TB] FAIL t4_hold_valid got %0b expected 1", out_valid[0]); else n_pass++;
               if (out_data[0] !== hd) $display("[TB] FAIL t4_hold_data got %0d expected %0d", out_data[0], hd); else n_pass++;
               if (out_ch[0] !== hc) $display("[TB] FAIL t4_hold_ch got %0d expected %0d", out_ch[0], hc); else n_pass++;
               @(posedge clk);
               #1;
            end
            out_ready[0] = 1'b1;
         end
      join
      repeat (5) @(posedge clk);
      #1;
      n_checks += 2;
      if (fails !== 0) $display("[TB] FAIL t4_accept_timeouts got %0d expected 0", fails); else n_pass++;
      if (mq[0].size() !== 40) $display("[TB] FAIL t4_count got %0d expected 40", mq[0].size()); else n_pass++;
      for (int i = 0; i < 40 && i < mq[0].size(); i++) begin
         logic signed [15:0] e;
         e = exp_act(acc4(i), bias_tb[i], 0);
         n_checks += 2;
         if (mq[0][i].data !== e) $display("[TB] FAIL t4_data[%0d] got %0d expected %0d", i, mq[0][i].data, e); else n_pass++;
         if (mq[0][i].ch !== 7'(i)) $display("[TB] FAIL t4_ch[%0d] got %0d expected %0d", i, mq[0][i].ch, i); else n_pass++;
      end
   endtask

   task automatic test_frac_shift();
      bit ok;
      do_reset(2);
      out_ready[2] = 1'b1;
      start_frame(2);
      for (int i = 0; i < 4; i++) applyStimulus(2, 32'd0, ok);
      applyStimulus(2, 32'd1000, ok);
      repeat (4) @(posedge clk);
      #1;
      n_checks += 4;
      if (mq[2].size() !== 5) $display("[TB] FAIL t7_count got %0d expected 5", mq[2].size()); else n_pass++;
      if (mq[2][0].data !== EXP_SH_CH0) $display("[TB] FAIL t7_ch0 got %0d expected %0d", mq[2][0].data, EXP_SH_CH0); else n_pass++;
      if (mq[2][4].data !== 16'sd70) $display("[TB] FAIL t7_shift got %0d expected 70", mq[2][4].data); else n_pass++;
      if (mq[2][4].ch !== 7'd4) $display("[TB] FAIL t7_ch got %0d expected 4", mq[2][4].ch); else n_pass++;
   endtask

   task automatic test_full_frame();
      bit ok;
      int fails, dcnt, lcnt;
      do_reset(0);
      out_ready[0] = 1'b1;
      start_frame(0);
      fails = 0;
      for (int w = 0; w < FRAME_WORDS; w++) begin
         applyStimulus(0, 32'd0, ok);
         if (!ok) fails++;
      end
      @(negedge clk);
      n_checks += 3;
      if (fails !== 0) $display("[TB] FAIL t5_accept_timeouts got %0d expected 0", fails); else n_pass++;
      if (acc_ready[0] !== 1'b0) $display("[TB] FAIL t5_drain_acc_ready got %0b expected 0", acc_ready[0]); else n_pass++;
      if (busy[0] !== 1'b1) $display("[TB] FAIL t5_drain_busy got %0b expected 1", busy[0]); else n_pass++;
      dcnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done[0]) dcnt++;
      end
      lcnt = 0;
      foreach (mq[0][i]) if (mq[0][i].last) lcnt++;
      n_checks += 5;
      if (dcnt !== 1) $display("[TB] FAIL t5_done_cycles got %0d expected 1", dcnt); else n_pass++;
      if (busy[0] !== 1'b0) $display("[TB] FAIL t5_busy_after got %0b expected 0", busy[0]); else n_pass++;
      if (mq[0].size() !== FRAME_WORDS) $display("[TB] FAIL t5_count got %0d expected %0d", mq[0].size(), FRAME_WORDS); else n_pass++;
      if (lcnt !== 1) $display("[TB] FAIL t5_last_count got %0d expected 1", lcnt); else n_pass++;
      if (mq[0][FRAME_WORDS-1].last !== 1'b1) $display("[TB] FAIL t5_last_pos got %0b expected 1", mq[0][FRAME_WORDS-1].last); else n_pass++;
      @(posedge clk);
      #1;
      mq[0].delete();
      start_frame(0);
      applyStimulus(0, 32'd0, ok);
      repeat (3) @(posedge clk);
      #1;
      n_checks += 3;
      if (mq[0].size() !== 1) $display("[TB] FAIL t5_restart_count got %0d expected 1", mq[0].size()); else n_pass++;
      if (mq[0][0].ch !== 7'd0) $display("[TB] FAIL t5_restart_ch got %0d expected 0", mq[0][0].ch); else n_pass++;
      if (mq[0][0].data !== EXP_CH0_ZERO) $display("[TB] FAIL t5_restart_data got %0d expected %0d", mq[0][0].data, EXP_CH0_ZERO); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int fails, dcnt;
      do_reset(1);
      out_ready[1] = 1'b1;
      start_frame(1);
      fails = 0;
      for (int w = 0; w < RST_WORDS; w++) begin
         applyStimulus(1, 32'd0, ok);
         if (!ok) fails++;
      end
      acc_valid[1] = 1'b1;
      acc_data[1]  = 32'd5;
      n_checks += 2;
      if (fails !== 0) $display("[TB] FAIL t6_accept_timeouts got %0d expected 0", fails); else n_pass++;
      if (out_valid[1] !== 1'b1) $display("[TB] FAIL t6_inflight got %0b expected 1", out_valid[1]); else n_pass++;
      #1;
      rst[1] = 1'b1;
      #1;
      n_checks += 6;
      if (out_valid[1] !== 1'b0) $display("[TB] FAIL t6_out_valid got %0b expected 0", out_valid[1]); else n_pass++;
      if (out_data[1] !== 16'sd0) $display("[TB] FAIL t6_out_data got %0d expected 0", out_data[1]); else n_pass++;
      if (out_ch[1] !== 7'd0) $display("[TB] FAIL t6_out_ch got %0d expected 0", out_ch[1]); else n_pass++;
      if (busy[1] !== 1'b0) $display("[TB] FAIL t6_busy got %0b expected 0", busy[1]); else n_pass++;
      if (acc_ready[1] !== 1'b0) $display("[TB] FAIL t6_acc_ready got %0b expected 0", acc_ready[1]); else n_pass++;
      if (out_last[1] !== 1'b0) $display("[TB] FAIL t6_out_last got %0b expected 0", out_last[1]); else n_pass++;
      acc_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      mq[1].delete();
      dcnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done[1]) dcnt++;
      end
      @(posedge clk);
      #1;
      start_frame(1);
      applyStimulus(1, 32'd0, ok);
      repeat (3) @(posedge clk);
      #1;
      n_checks += 3;
      if (dcnt !== 0) $display("[TB] FAIL t6_no_done got %0d expected 0", dcnt); else n_pass++;
      if (mq[1][0].ch !== 7'd0) $display("[TB] FAIL t6_restart_ch got %0d expected 0", mq[1][0].ch); else n_pass++;
      if (mq[1][0].data !== EXP_CH0_ZERO) $display("[TB] FAIL t6_restart_data got %0d expected %0d", mq[1][0].data, EXP_CH0_ZERO); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) bias_tb[i] = 32'((i * 37) % 401 - 200);
      bias_tb[0] = -32'sd61;
      bias_tb[1] = 32'sd20;
      bias_tb[2] = -32'sd7;
      bias_tb[3] = 32'sd266;
      bias_tb[4] = 32'sd135;
      bias_tb[5] = -32'sd122;
      start     = 3'b000;
      acc_valid = 3'b000;
      out_ready = 3'b000;
      for (int d = 0; d < 3; d++) acc_data[d] = 32'd0;
      test_reset();
      test_basic_latency();
      test_saturation();
      test_relu();
      test_back_to_back();
      test_frac_shift();
      fork
         test_full_frame();
         test_reset_mid_frame();
      join
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
